// File: rtl/data_memory_responder_if.sv
// Host and processor port bundle for the data-memory responder.
// The responder uses the slave modport; a host/processor model uses master.
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int BUS_WIDTH  = 24
);
  logic                  start;
  logic                  host_clear;
  logic                  host_valid;
  logic                  host_ready;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [7:0]            host_wdata;
  logic [7:0]            host_rdata;
  logic                  host_rvalid;
  logic                  dm_en;
  logic [ADDR_WIDTH-1:0] ar_out;
  logic [BUS_WIDTH-1:0]  bus_out;
  logic [7:0]            dm_out;
  logic                  end_process;
  logic [1:0]            status;
  logic                  addr_err;
  logic [15:0]           wr_count;

  modport slave (
    input  start, host_clear, host_valid, host_we, host_addr, host_wdata,
    input  dm_en, ar_out, bus_out, end_process,
    output host_ready, host_rdata, host_rvalid, dm_out, status, addr_err, wr_count
  );

  modport master (
    output start, host_clear, host_valid, host_we, host_addr, host_wdata,
    output dm_en, ar_out, bus_out, end_process,
    input  host_ready, host_rdata, host_rvalid, dm_out, status, addr_err, wr_count
  );
endinterface

// File: rtl/data_memory_responder.sv
// Byte-wide data RAM shared between a host load/drain port (IDLE/DONE) and
// the processor port (RUN), with IDLE/RUN/DONE sequencing and status output.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4096,
  parameter int BUS_WIDTH  = 24
) (
  input logic                    clock,
  input logic                    rst_r,
  data_memory_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] DEPTH_X = 33'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [7:0]            r_mem [0:DEPTH-1];
  logic [7:0]            r_dm_out;
  logic [7:0]            r_host_rdata;
  logic                  r_host_rvalid;
  logic                  r_addr_err;
  logic [15:0]           r_wr_count;

  logic                  w_run;
  logic                  w_host_acc;
  logic                  w_host_rd;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range;
  logic [7:0]            w_rd_data;
  logic [7:0]            w_wdata;
  logic                  w_proc_wr;
  logic                  w_err;
  logic                  w_cnt_clr;
  logic                  w_unused_bus;

  // One shared address: the processor owns the RAM in RUN, the host otherwise.
  assign w_run      = (r_state == S_RUN);
  assign w_host_acc = bus.host_valid & ~w_run;
  assign w_host_rd  = w_host_acc & ~bus.host_we;
  assign w_addr     = w_run ? bus.ar_out : bus.host_addr;
  assign w_in_range = ({{(33-ADDR_WIDTH){1'b0}}, w_addr} < DEPTH_X);
  assign w_idx      = w_addr[IDX_W-1:0];
  assign w_rd_data  = w_in_range ? r_mem[w_idx] : 8'h00;
  assign w_wdata    = w_run ? bus.bus_out[7:0] : bus.host_wdata;
  assign w_proc_wr  = w_run & bus.dm_en & ~rst_r;
  assign w_mem_we   = (w_proc_wr | (w_host_acc & bus.host_we & ~rst_r)) & w_in_range;
  assign w_err      = (w_run | w_host_acc) & ~w_in_range;
  assign w_cnt_clr  = ((r_state == S_IDLE) & bus.start) | ((r_state == S_DONE) & bus.host_clear);
  assign w_unused_bus = ^bus.bus_out[BUS_WIDTH-1:8];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start)       w_next = S_RUN;
      S_RUN:   if (bus.end_process) w_next = S_DONE;
      S_DONE:  if (bus.host_clear)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst_r) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // RAM contents survive reset; the read side sees pre-write data.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_idx] <= w_wdata;
  end

  always_ff @(posedge clock) begin
    if (rst_r) begin
      r_dm_out      <= 8'h00;
      r_host_rdata  <= 8'h00;
      r_host_rvalid <= 1'b0;
      r_addr_err    <= 1'b0;
      r_wr_count    <= 16'h0000;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) r_host_rdata <= w_rd_data;

      if (w_run)                 r_dm_out <= w_rd_data;
      else if (w_next == S_IDLE) r_dm_out <= 8'h00;

      if ((r_state == S_DONE) & bus.host_clear) r_addr_err <= 1'b0;
      if (w_err)                                r_addr_err <= 1'b1;

      if (w_cnt_clr)
        r_wr_count <= 16'h0000;
      else if (w_proc_wr & w_in_range & (r_wr_count != 16'hFFFF))
        r_wr_count <= r_wr_count + 16'h0001;
    end
  end

  assign bus.status      = r_state;
  assign bus.host_ready  = ~w_run;
  assign bus.host_rdata  = r_host_rdata;
  assign bus.host_rvalid = r_host_rvalid;
  assign bus.dm_out      = r_dm_out;
  assign bus.addr_err    = r_addr_err;
  assign bus.wr_count    = r_wr_count;
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Data-memory side of the processor's memory interface.
- Owns an 8-bit-wide RAM. Services processor accesses (address, write enable, 24-bit bus write data) during a run. Returns registered read data to the processor.
- Exposes a host port for loading matrices before a run and draining results after it. Drives the processor's 2-bit status input and sequences IDLE/RUN/DONE.

Parameters:
ADDR_WIDTH, 16, processor address width (AR width)
DEPTH, 4096, number of 8-bit words; addresses >= DEPTH are out of range
BUS_WIDTH, 24, processor bus width; only bits [7:0] are stored

Ports:
clock  in  1  system clock, all state updates on rising edge
rst_r  in  1  synchronous active-high reset
start  in  1  host pulse: begin processor run (honoured only in IDLE)
host_clear  in  1  host pulse: DONE -> IDLE, clears addr_err and wr_count
host_valid  in  1  host access request
host_ready  out  1  host access accepted when host_valid & host_ready
host_we  in  1  1 = host write, 0 = host read
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  8  host write data
host_rdata  out  8  host read data
host_rvalid  out  1  one-cycle pulse, host_rdata valid
dm_en  in  1  processor write enable
ar_out  in  ADDR_WIDTH  processor address
bus_out  in  BUS_WIDTH  processor write data
dm_out  out  8  registered read data to processor
end_process  in  1  processor finished
status  out  2  to processor: 00 IDLE, 01 RUN, 10 DONE
addr_err  out  1  sticky: out-of-range access attempted
wr_count  out  16  processor writes performed during the run, saturating at 16'hFFFF

Behaviour:
- Reset (rst_r = 1 at a clock edge) forces the following. RAM contents are NOT cleared.
  - state = IDLE, status = 00, host_ready = 1
  - host_rvalid = 0, host_rdata = 0, dm_out = 0
  - addr_err = 0, wr_count = 0
- Reset mid-RUN aborts the run. Any dm_en in that cycle is ignored.
- State machine:
  - IDLE: host_ready = 1, processor port ignored (dm_out held at 0). start = 1 -> RUN next cycle.
  - RUN: host_ready = 0, host_valid ignored, start ignored. end_process = 1 -> DONE next cycle.
  - DONE: host_ready = 1, processor port ignored (dm_out holds its last value). host_clear = 1 -> IDLE. start ignored.
- Status: status is registered and reflects the current state. It changes one cycle after the triggering input.
- Host access (IDLE or DONE, host_valid & host_ready):
  - Write: mem[host_addr] <= host_wdata at the accepting edge.
  - Read: host_rdata <= mem[host_addr] at the accepting edge, host_rvalid = 1 for exactly that following cycle. Otherwise host_rvalid = 0 and host_rdata holds.
  - Back-to-back accesses every cycle are allowed.
- Processor access (RUN only):
  - Every cycle, dm_out <= mem[ar_out]: one-cycle read latency.
  - If dm_en = 1: mem[ar_out] <= bus_out[7:0]; bus_out[23:8] is discarded; wr_count += 1 (saturating).
  - Same-address read and write in one cycle: dm_out returns the OLD data (read-before-write).
- Out of range (addr >= DEPTH), host or processor:
  - Write is dropped and read returns 8'h00.
  - addr_err <= 1, sticky until host_clear or reset.
  - An out-of-range write does not increment wr_count.
- Simultaneous events:
  - start with an accepted host access in IDLE: the access completes (rvalid the next cycle), RUN starts the next cycle.
  - end_process with dm_en in RUN: the write is performed and counted, then DONE.
  - host_clear with an accepted host access in DONE: the access completes, then IDLE.
  - start and host_clear together: only the one valid for the current state acts.
- wr_count clears on entry to RUN from IDLE (start accepted). It holds its value through DONE for host inspection.
- Width rules:
  - Addresses compare unsigned against DEPTH.
  - Memory is indexed by the low log2(DEPTH) bits only after the range check passes.

Test Plan:
- Host load then readback: in IDLE write 8'hA5 to 0x0010 and 8'h3C to 0x0011, then read 0x0010 -> host_rvalid pulses one cycle after acceptance with host_rdata = 8'hA5; status = 00 throughout.
- Run read/write: start -> status = 01 the next cycle. Processor ar_out = 0x0010 gives dm_out = 8'hA5 one cycle later. dm_en with ar_out = 0x0020, bus_out = 24'h1234_56 stores 8'h56 and wr_count = 1. end_process -> status = 10. Host read 0x0020 returns 8'h56.
- Read-before-write: in RUN, ar_out = 0x0011, dm_en = 1, bus_out = 24'h0000_77 -> dm_out next cycle = 8'h3C. The following cycle with the same address gives dm_out = 8'h77.
- Host blocked in RUN: host_valid = 1 during RUN -> host_ready = 0, no host_rvalid, memory unchanged. After DONE the same request is accepted.
- Out of range: processor write to 0x1000 (DEPTH = 4096) with dm_en -> addr_err = 1, wr_count unchanged. A read of 0x1000 returns dm_out = 8'h00. host_clear -> addr_err = 0, status = 00.
- Reset mid-run: rst_r during RUN with dm_en = 1, ar_out = 0x0010 -> status = 00, dm_out = 0, wr_count = 0. Host read of 0x0010 afterwards still returns 8'hA5.
